booth_seq_ctrl: RTL and testbench

Sequencing and handshake controller for the radix-4 Booth multiplier datapath. It accepts signed operand pairs over a valid/ready input channel and registers them. It drives the datapath's load, operand-evaluate and accumulate/shift enables through `INPUT_WIDTH/2` two-cycle iterations. It then captures the product into a holding register and presents it on a valid/ready output channel. It sits directly upstream of the datapath, and its `dp_*` outputs connect one-to-one to the datapath's load/enable/operand pins.

---
 rtl/booth_seq_ctrl.sv | 105 ++++++++++
 tb/tb_booth_seq_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_ctrl.sv
// rtl/booth_seq_ctrl.sv - sequencing/handshake controller for a radix-4 Booth multiplier datapath
// One job at a time: accept operands, drive load/eval/acc pulses, capture and hold the product.
module booth_seq_ctrl #(
   parameter int INPUT_WIDTH  = 6,
   parameter int OUTPUT_WIDTH = 2 * INPUT_WIDTH,
   parameter int ITER         = INPUT_WIDTH / 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [INPUT_WIDTH-1:0]  in_a,
   input  logic [INPUT_WIDTH-1:0]  in_b,
   output logic                    dp_load,
   output logic                    dp_en_inp,
   output logic                    dp_en_p,
   output logic [INPUT_WIDTH-1:0]  dp_multiplicand,
   output logic [INPUT_WIDTH-1:0]  dp_multiplier,
   input  logic [OUTPUT_WIDTH-1:0] dp_product,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUTPUT_WIDTH-1:0] out_product
);

   localparam int CW = $clog2(ITER + 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      EVAL,
      ACC,
      CAPT,
      HOLD
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   // Enables are registered alongside the next state, so each is high exactly
   // while the FSM sits in its matching state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         cnt             <= '0;
         in_ready        <= 1'b1;
         dp_load         <= 1'b0;
         dp_en_inp       <= 1'b0;
         dp_en_p         <= 1'b0;
         dp_multiplicand <= '0;
         dp_multiplier   <= '0;
         out_valid       <= 1'b0;
         out_product     <= '0;
      end else begin
         dp_load   <= 1'b0;
         dp_en_inp <= 1'b0;
         dp_en_p   <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  dp_multiplicand <= in_a;
                  dp_multiplier   <= in_b;
                  cnt             <= '0;
                  in_ready        <= 1'b0;
                  dp_load         <= 1'b1;
                  state           <= LOAD;
               end
            end
            LOAD: begin
               dp_en_inp <= 1'b1;
               state     <= EVAL;
            end
            EVAL: begin
               dp_en_p <= 1'b1;
               state   <= ACC;
            end
            ACC: begin
               cnt <= cnt + CW'(1);
               if (cnt == CW'(ITER - 1)) begin
                  state <= CAPT;
               end else begin
                  dp_en_inp <= 1'b1;
                  state     <= EVAL;
               end
            end
            CAPT: begin
               out_product <= dp_product;
               out_valid   <= 1'b1;
               state       <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               in_ready <= 1'b1;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// tb/tb_booth_seq_ctrl.sv - self-checking bench for booth_seq_ctrl
// Includes a behavioural radix-4 Booth datapath driven by the controller's dp_* pins.
module tb_booth_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  in_a;
   logic [5:0]  in_b;
   logic        dp_load;
   logic        dp_en_inp;
   logic        dp_en_p;
   logic [5:0]  dp_multiplicand;
   logic [5:0]  dp_multiplier;
   logic [11:0] dp_product;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_product;

   int errors = 0;
   int checks = 0;
   int excl_viol = 0;

   always #5 clk = ~clk;

   booth_seq_ctrl dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .dp_load(dp_load), .dp_en_inp(dp_en_inp), .dp_en_p(dp_en_p),
      .dp_multiplicand(dp_multiplicand), .dp_multiplier(dp_multiplier),
      .dp_product(dp_product),
      .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product)
   );

   // Datapath model: digit-serial Booth accumulation, weighted by 4^step.
   int dp_acc;
   int dp_addend;
   int dp_step;

   function automatic int booth_addend(logic [5:0] b, int s, logic [5:0] a);
      logic [6:0] bx;
      int d;
      bx = {b, 1'b0};
      d  = -2 * int'(bx[2*s+2]) + int'(bx[2*s+1]) + int'(bx[2*s]);
      return d * int'($signed(a));
   endfunction

   always @(posedge clk) begin
      if (dp_load) begin
         dp_acc    <= 0;
         dp_addend <= 0;
         dp_step   <= 0;
      end else if (dp_en_inp) begin
         dp_addend <= booth_addend(dp_multiplier, dp_step, dp_multiplicand);
      end else if (dp_en_p) begin
         dp_acc  <= dp_acc + (dp_addend <<< (2 * dp_step));
         dp_step <= dp_step + 1;
      end
   end
   assign dp_product = dp_acc[11:0];

   always @(negedge clk) begin
      if (!rst) begin
         if (int'(dp_load) + int'(dp_en_inp) + int'(dp_en_p) > 1) excl_viol <= excl_viol + 1;
         if (in_ready && (dp_load || dp_en_inp || dp_en_p)) excl_viol <= excl_viol + 1;
      end
   end

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called just after a negedge with the FSM idle; returns just after the handshake edge.
   task automatic start_job(int a, int b);
      in_valid = 1'b1;
      in_a     = 6'(a);
      in_b     = 6'(b);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat, output logic [23:0] trace, output bit rdy_seen);
      int cyc;
      cyc      = 0;
      trace    = '0;
      rdy_seen = 1'b0;
      while (cyc < 20) begin
         @(negedge clk);
         if (out_valid) break;
         if (cyc < 8) trace[23-3*cyc -: 3] = {dp_load, dp_en_inp, dp_en_p};
         if (in_ready) rdy_seen = 1'b1;
         cyc++;
      end
      lat = cyc;
   endtask

   task automatic table_job(int a, int b, int exp, string name);
      int          lat;
      logic [23:0] trace;
      bit          rdy_seen;
      out_ready = 1'b1;
      start_job(a, b);
      wait_result(lat, trace, rdy_seen);
      chk({name, "_latency"}, lat, 8);
      chk({name, "_enable_seq"}, int'(trace), int'(24'o42121210));
      chk({name, "_in_ready_low"}, int'(rdy_seen), 0);
      chk({name, "_product"}, int'(out_product), exp);
      @(posedge clk);
      @(negedge clk);
      chk({name, "_idle_ready"}, int'(in_ready), 1);
      chk({name, "_idle_valid"}, int'(out_valid), 0);
   endtask

   typedef struct {
      int    a;
      int    b;
      int    exp;
      string name;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int          lat;
      logic [23:0] trace;
      bit          rdy_seen;
      bit          bad;
      int          a;
      int          b;
      int          guard;

      vecs[0] = '{7,   -5,  'hFDD, "basic_7x-5"};
      vecs[1] = '{31,  31,  'h3C1, "max_31x31"};
      vecs[2] = '{-31, -31, 'h3C1, "neg_-31x-31"};
      vecs[3] = '{31,  -32, 'hC20, "minb_31x-32"};
      vecs[4] = '{1,   1,   'h001, "one_1x1"};
      vecs[5] = '{-1,  -32, 'h020, "neg1_-1x-32"};
      vecs[6] = '{15,  -16, 'hF10, "mid_15x-16"};
      vecs[7] = '{-31, 31,  'hC3F, "mix_-31x31"};

      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_in_ready", int'(in_ready), 1);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_product", int'(out_product), 0);
      chk("reset_enables", int'({dp_load, dp_en_inp, dp_en_p}), 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) table_job(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

      // Zero product held under backpressure; new operands must be ignored.
      out_ready = 1'b0;
      start_job(0, -17);
      wait_result(lat, trace, rdy_seen);
      chk("bp_latency", lat, 8);
      chk("bp_product", int'(out_product), 0);
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_a = 6'd5; in_b = 6'd5;
         @(negedge clk);
         if (!out_valid || out_product != 12'h000 || in_ready ||
             dp_multiplicand != 6'h00 || dp_multiplier != 6'h2F) bad = 1'b1;
      end
      chk("bp_hold_stable", int'(bad), 0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_release_ready", int'(in_ready), 1);
      chk("bp_release_valid", int'(out_valid), 0);

      // Reset during the second ACC discards the job.
      start_job(5, 9);
      repeat (5) @(negedge clk);
      chk("midrst_in_acc", int'(dp_en_p), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_enables", int'({dp_load, dp_en_inp, dp_en_p}), 0);
      chk("midrst_ready", int'(in_ready), 1);
      bad = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) bad = 1'b1;
      end
      chk("midrst_no_result", int'(bad), 0);
      table_job(-3, 6, 'hFEE, "after_rst_-3x6");

      // Reset and handshake on the same edge: reset wins.
      rst = 1'b1; in_valid = 1'b1; in_a = 6'd9; in_b = 6'd9;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      chk("rst_hs_operand", int'(dp_multiplicand), 0);
      chk("rst_hs_no_load", int'(dp_load), 0);
      @(negedge clk);
      chk("rst_hs_idle", int'(in_ready), 1);

      // Random in-range jobs with random output backpressure.
      for (int j = 0; j < 200; j++) begin
         a = int'($urandom_range(0, 62)) - 31;
         b = int'($urandom_range(0, 63)) - 32;
         chk("rand_start_ready", int'(in_ready), 1);
         out_ready = 1'b0;
         start_job(a, b);
         wait_result(lat, trace, rdy_seen);
         chk("rand_product", int'(out_product), (a * b) & 'hFFF);
         guard = 0;
         while (guard < 20) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            if (out_ready) break;
            @(negedge clk);
            guard++;
         end
         @(negedge clk);
         out_ready = 1'b0;
      end
      chk("exclusive_enables", excl_viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
